// File: rtl/axi_merge_2x1_pkg.sv
// Shared types and helpers for the 2-to-1 stream merger and its input FIFOs.
package axi_merge_2x1_pkg;

    typedef enum logic {
        SRC_I1 = 1'b0,
        SRC_I2 = 1'b1
    } src_e;

    function automatic int fifo_depth(input int depth_log2);
        return 1 << depth_log2;
    endfunction

endpackage

// File: rtl/axi_fifo_sync.sv
// Synchronous first-word-fall-through FIFO; a write into a full FIFO is
// accepted when a read happens in the same cycle.
module axi_fifo_sync
    import axi_merge_2x1_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = fifo_depth(DEPTH_LOG2);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_wr;
    logic                  do_rd;

    assign full    = (level == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    // Storage carries no reset; only the pointers and level define validity.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/axi_merge_2x1.sv
// Merges two valid-only streams through per-input FIFOs into one registered
// output with a round-robin arbiter and sticky overflow flags.
module axi_merge_2x1
    import axi_merge_2x1_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      I1_tdata,
    input  logic                  I1_tvalid,
    input  logic [WIDTH-1:0]      I2_tdata,
    input  logic                  I2_tvalid,
    output logic [WIDTH-1:0]      O_tdata,
    output logic                  O_tvalid,
    input  logic                  O_tready,
    output logic                  O_tsel,
    output logic [1:0]            ovf,
    output logic [DEPTH_LOG2:0]   level1,
    output logic [DEPTH_LOG2:0]   level2
);

    // Output handshake: O_tdata/O_tsel are meaningful while O_tvalid=1 and
    // hold stable until a cycle with O_tready=1 consumes them.

    logic [WIDTH-1:0] rd_data1, rd_data2;
    logic             full1, full2;
    logic             empty1, empty2;
    logic             pop1, pop2;
    logic             load;
    logic             grant_valid;
    logic             tie;
    src_e             grant;
    src_e             last;

    axi_fifo_sync #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (I1_tvalid),
        .wr_data (I1_tdata),
        .rd_en   (pop1),
        .rd_data (rd_data1),
        .full    (full1),
        .empty   (empty1),
        .level   (level1)
    );

    axi_fifo_sync #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (I2_tvalid),
        .wr_data (I2_tdata),
        .rd_en   (pop2),
        .rd_data (rd_data2),
        .full    (full2),
        .empty   (empty2),
        .level   (level2)
    );

    assign load = !O_tvalid || O_tready;

    always_comb begin
        grant_valid = 1'b0;
        grant       = SRC_I1;
        tie         = 1'b0;
        if (load) begin
            if (!empty1 && !empty2) begin
                grant_valid = 1'b1;
                tie         = 1'b1;
                grant       = (last == SRC_I1) ? SRC_I2 : SRC_I1;
            end else if (!empty1) begin
                grant_valid = 1'b1;
                grant       = SRC_I1;
            end else if (!empty2) begin
                grant_valid = 1'b1;
                grant       = SRC_I2;
            end
        end
    end

    assign pop1 = grant_valid && (grant == SRC_I1);
    assign pop2 = grant_valid && (grant == SRC_I2);

    // last only moves when both sources compete; reset value lets I1 win first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last     <= SRC_I2;
            O_tdata  <= '0;
            O_tsel   <= 1'b0;
            O_tvalid <= 1'b0;
            ovf      <= 2'b00;
        end else begin
            if (tie) begin
                last <= grant;
            end
            if (load) begin
                if (grant_valid) begin
                    O_tdata  <= (grant == SRC_I2) ? rd_data2 : rd_data1;
                    O_tsel   <= grant;
                    O_tvalid <= 1'b1;
                end else begin
                    O_tvalid <= 1'b0;
                end
            end
            if (I1_tvalid && full1 && !pop1) begin
                ovf[0] <= 1'b1;
            end
            if (I2_tvalid && full2 && !pop2) begin
                ovf[1] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_merge_2x1.sv
// Randomised and directed bench for axi_merge_2x1 against a queue-based model.
module tb_axi_merge_2x1;

    localparam int W     = 16;
    localparam int DL2   = 3;
    localparam int DEPTH = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [W-1:0]   i1_tdata = '0;
    logic           i1_tvalid = 1'b0;
    logic [W-1:0]   i2_tdata = '0;
    logic           i2_tvalid = 1'b0;
    logic [W-1:0]   o_tdata;
    logic           o_tvalid;
    logic           o_tready = 1'b1;
    logic           o_tsel;
    logic [1:0]     ovf;
    logic [DL2:0]   level1;
    logic [DL2:0]   level2;

    int n_cmp = 0;
    int n_err = 0;

    axi_merge_2x1 #(.WIDTH(W), .DEPTH_LOG2(DL2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .I1_tdata  (i1_tdata),
        .I1_tvalid (i1_tvalid),
        .I2_tdata  (i2_tdata),
        .I2_tvalid (i2_tvalid),
        .O_tdata   (o_tdata),
        .O_tvalid  (o_tvalid),
        .O_tready  (o_tready),
        .O_tsel    (o_tsel),
        .ovf       (ovf),
        .level1    (level1),
        .level2    (level2)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [W-1:0] exp_q1[$];
    logic [W-1:0] exp_q2[$];
    logic [W-1:0] m_data = '0;
    logic         m_valid = 1'b0;
    logic         m_sel = 1'b0;
    logic         m_last = 1'b1;
    logic [1:0]   m_ovf = 2'b00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q1.delete();
            exp_q2.delete();
            m_data  = '0;
            m_valid = 1'b0;
            m_sel   = 1'b0;
            m_last  = 1'b1;
            m_ovf   = 2'b00;
        end else begin
            bit have1, have2;
            have1 = exp_q1.size() > 0;
            have2 = exp_q2.size() > 0;
            if (!m_valid || o_tready) begin
                if (have1 && have2) begin
                    m_sel  = ~m_last;
                    m_last = m_sel;
                end else if (have1) begin
                    m_sel = 1'b0;
                end else if (have2) begin
                    m_sel = 1'b1;
                end
                if (have1 || have2) begin
                    m_data  = m_sel ? exp_q2.pop_front() : exp_q1.pop_front();
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
            // After the pop, room in the queue means the word is accepted.
            if (i1_tvalid) begin
                if (exp_q1.size() < DEPTH) exp_q1.push_back(i1_tdata);
                else m_ovf[0] = 1'b1;
            end
            if (i2_tvalid) begin
                if (exp_q2.size() < DEPTH) exp_q2.push_back(i2_tdata);
                else m_ovf[1] = 1'b1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_tvalid", 32'(o_tvalid), 32'(m_valid));
            chk("m_tdata", 32'(o_tdata), 32'(m_data));
            chk("m_tsel", 32'(o_tsel), 32'(m_sel));
            chk("m_ovf", 32'(ovf), 32'(m_ovf));
            chk("m_level1", 32'(level1), 32'(exp_q1.size()));
            chk("m_level2", 32'(level2), 32'(exp_q2.size()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v1, input logic [W-1:0] d1,
                         input logic v2, input logic [W-1:0] d2, input logic rdy);
        @(negedge clk);
        i1_tvalid = v1;
        i1_tdata  = d1;
        i2_tvalid = v2;
        i2_tdata  = d2;
        o_tready  = rdy;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", 32'(o_tvalid), 32'h0);
        chk("rst_tdata", 32'(o_tdata), 32'h0);
        chk("rst_tsel", 32'(o_tsel), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        chk("rst_level1", 32'(level1), 32'h0);
        chk("rst_level2", 32'(level2), 32'h0);
        rst_n = 1'b1;

        // I1 only, three consecutive words
        drive(1'b1, 16'h0001, 1'b0, '0, 1'b1);
        drive(1'b1, 16'h0002, 1'b0, '0, 1'b1);
        chk("t1_level1_a", 32'(level1), 32'h1);
        chk("t1_valid_a", 32'(o_tvalid), 32'h0);
        drive(1'b1, 16'h0003, 1'b0, '0, 1'b1);
        chk("t1_w1", 32'(o_tdata), 32'h0001);
        chk("t1_valid_b", 32'(o_tvalid), 32'h1);
        chk("t1_sel", 32'(o_tsel), 32'h0);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        chk("t1_w2", 32'(o_tdata), 32'h0002);
        chk("t1_level1_b", 32'(level1), 32'h1);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        chk("t1_w3", 32'(o_tdata), 32'h0003);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        chk("t1_empty_valid", 32'(o_tvalid), 32'h0);
        chk("t1_empty_hold", 32'(o_tdata), 32'h0003);

        // both sources every cycle
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 16'(16'h1000 + k), 1'b1, 16'(16'h2000 + k), 1'b1);
            if (k == 2) begin
                chk("t2_first", 32'(o_tdata), 32'h1000);
                chk("t2_first_sel", 32'(o_tsel), 32'h0);
            end
            if (k == 3) begin
                chk("t2_second", 32'(o_tdata), 32'h2000);
                chk("t2_second_sel", 32'(o_tsel), 32'h1);
            end
        end
        idle(10);

        // stall while I2 overfills
        for (int i = 0; i < 12; i++)
            drive(1'b0, '0, (i < 10), 16'(16'h3001 + i), 1'b0);
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        chk("t3_hold", 32'(o_tdata), 32'h3001);
        chk("t3_level2", 32'(level2), 32'h8);
        chk("t3_ovf", 32'(ovf), 32'h2);
        idle(12);

        // FIFO1 full, pop and push in the same cycle
        for (int i = 0; i < 9; i++)
            drive(1'b1, 16'(16'h4001 + i), 1'b0, '0, 1'b0);
        drive(1'b1, 16'h400a, 1'b0, '0, 1'b1);
        chk("t4_full", 32'(level1), 32'h8);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        chk("t4_level_hold", 32'(level1), 32'h8);
        chk("t4_ovf0", 32'(ovf[0]), 32'h0);
        idle(14);

        // single I2 word after an empty spell
        drive(1'b0, '0, 1'b1, 16'h5555, 1'b1);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        chk("t6_valid", 32'(o_tvalid), 32'h1);
        chk("t6_sel", 32'(o_tsel), 32'h1);
        chk("t6_data", 32'(o_tdata), 32'h5555);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        chk("t6_valid_drop", 32'(o_tvalid), 32'h0);
        chk("t6_data_hold", 32'(o_tdata), 32'h5555);

        // randomised traffic
        for (int i = 0; i < 400; i++)
            drive(($urandom_range(0, 99) < 45), 16'($urandom),
                  ($urandom_range(0, 99) < 45), 16'($urandom),
                  ($urandom_range(0, 99) < 70));
        idle(20);

        // asynchronous reset in the middle of a burst
        for (int i = 0; i < 6; i++)
            drive(1'b1, 16'($urandom), 1'b1, 16'($urandom), 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(o_tvalid), 32'h0);
        chk("ar_level1", 32'(level1), 32'h0);
        chk("ar_level2", 32'(level2), 32'h0);
        chk("ar_ovf", 32'(ovf), 32'h0);
        @(negedge clk);
        i1_tvalid = 1'b0;
        i2_tvalid = 1'b0;
        rst_n = 1'b1;
        drive(1'b1, 16'h6001, 1'b1, 16'h7001, 1'b1);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        chk("ar_tie_data", 32'(o_tdata), 32'h6001);
        chk("ar_tie_sel", 32'(o_tsel), 32'h0);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        chk("ar_next_data", 32'(o_tdata), 32'h7001);
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
